// File: rtl/sia_txdma.sv
// sia_txdma: transmit DMA sequencer for the SIA.
// Copies a block of 16-bit words from memory into the SIA transmit data
// register. Each word is read over the memory Wishbone pipelined master,
// then written over the SIA master once the SIA reports room (dreq_i).
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   start_i, abort_i          control: start pulse (idle only), abort level
//   src_adr_i, count_i        transfer source word address and length
//   busy_o, done_o, aborted_o status: busy, completion pulse, sticky abort
//   mem_*                     Wishbone B.4 pipelined master, memory reads
//   sia_*                     Wishbone B.4 pipelined master, SIA TX writes
//   dreq_i                    SIA txq_not_full, paces each write
module sia_txdma #(
    parameter logic [2:0]  SIA_ADR_TX = 3'b010,
    parameter int unsigned AW         = 23,
    parameter int unsigned CW         = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [AW-1:0] src_adr_i,
    input  logic [CW-1:0] count_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          aborted_o,
    output logic [AW:1]   mem_adr_o,
    output logic          mem_cyc_o,
    output logic          mem_stb_o,
    output logic [1:0]    mem_sel_o,
    input  logic [15:0]   mem_dat_i,
    input  logic          mem_ack_i,
    input  logic          mem_stall_i,
    output logic [2:0]    sia_adr_o,
    output logic          sia_cyc_o,
    output logic          sia_stb_o,
    output logic          sia_we_o,
    output logic [1:0]    sia_sel_o,
    output logic [15:0]   sia_dat_o,
    input  logic          sia_ack_i,
    input  logic          sia_stall_i,
    input  logic          dreq_i
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_REQ    = 3'd1,
        S_RD_WAIT   = 3'd2,
        S_WAIT_DREQ = 3'd3,
        S_WR_REQ    = 3'd4,
        S_WR_WAIT   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW:1]   addr;
    logic [AW:1]   addr_nxt;
    logic [CW-1:0] remain;
    logic [CW-1:0] remain_nxt;
    logic [15:0]   data_buf;
    logic [15:0]   data_buf_nxt;
    logic          done_nxt;
    logic          aborted_nxt;

    // Next-cycle output values, registered below.
    logic          busy_c;
    logic [AW:1]   mem_adr_c;
    logic          mem_cyc_c;
    logic          mem_stb_c;
    logic [1:0]    mem_sel_c;
    logic [2:0]    sia_adr_c;
    logic          sia_cyc_c;
    logic          sia_stb_c;
    logic          sia_we_c;
    logic [1:0]    sia_sel_c;
    logic [15:0]   sia_dat_c;

    // State, datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= S_IDLE;
            addr      <= '0;
            remain    <= '0;
            data_buf  <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            aborted_o <= 1'b0;
            mem_adr_o <= '0;
            mem_cyc_o <= 1'b0;
            mem_stb_o <= 1'b0;
            mem_sel_o <= 2'b00;
            sia_adr_o <= 3'b000;
            sia_cyc_o <= 1'b0;
            sia_stb_o <= 1'b0;
            sia_we_o  <= 1'b0;
            sia_sel_o <= 2'b00;
            sia_dat_o <= 16'h0000;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remain    <= remain_nxt;
            data_buf  <= data_buf_nxt;
            busy_o    <= busy_c;
            done_o    <= done_nxt;
            aborted_o <= aborted_nxt;
            mem_adr_o <= mem_adr_c;
            mem_cyc_o <= mem_cyc_c;
            mem_stb_o <= mem_stb_c;
            mem_sel_o <= mem_sel_c;
            sia_adr_o <= sia_adr_c;
            sia_cyc_o <= sia_cyc_c;
            sia_stb_o <= sia_stb_c;
            sia_we_o  <= sia_we_c;
            sia_sel_o <= sia_sel_c;
            sia_dat_o <= sia_dat_c;
        end
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        remain_nxt   = remain;
        data_buf_nxt = data_buf;
        done_nxt     = 1'b0;
        aborted_nxt  = aborted_o;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (count_i != '0) begin
                        addr_nxt    = src_adr_i;
                        remain_nxt  = count_i;
                        aborted_nxt = 1'b0;
                        state_nxt   = S_RD_REQ;
                    end else begin
                        // Empty transfer: complete immediately, no bus traffic.
                        done_nxt = 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (!mem_stall_i) begin
                    state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_ack_i) begin
                    data_buf_nxt = mem_dat_i;
                    state_nxt    = S_WAIT_DREQ;
                end
            end
            S_WAIT_DREQ: begin
                if (dreq_i) begin
                    state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (!sia_stall_i) begin
                    state_nxt = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (sia_ack_i) begin
                    remain_nxt = remain - CW'(1);
                    addr_nxt   = addr + AW'(1);
                    if (remain_nxt == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_RD_REQ;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides sequencing, but a word acked this cycle still counts.
        if (abort_i && (state != S_IDLE)) begin
            state_nxt   = S_IDLE;
            done_nxt    = 1'b1;
            aborted_nxt = 1'b1;
        end
    end

    // Bus outputs decoded from the next state so they line up with it.
    always_comb begin
        busy_c    = (state_nxt != S_IDLE);
        mem_cyc_c = (state_nxt == S_RD_REQ) || (state_nxt == S_RD_WAIT);
        mem_stb_c = (state_nxt == S_RD_REQ);
        mem_sel_c = mem_stb_c ? 2'b11 : 2'b00;
        mem_adr_c = mem_cyc_c ? addr_nxt : '0;
        sia_cyc_c = (state_nxt == S_WR_REQ) || (state_nxt == S_WR_WAIT);
        sia_stb_c = (state_nxt == S_WR_REQ);
        sia_we_c  = sia_cyc_c;
        sia_adr_c = sia_cyc_c ? SIA_ADR_TX : 3'b000;
        sia_sel_c = sia_cyc_c ? 2'b11 : 2'b00;
        sia_dat_c = sia_cyc_c ? data_buf_nxt : 16'h0000;
    end

endmodule

// File: tb/tb_sia_txdma.sv
// Scoreboard bench for sia_txdma: stimulus pushes expected bus traffic,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_sia_txdma;

    localparam int unsigned AW = 23;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic          abort_i;
    logic [AW-1:0] src_adr_i;
    logic [CW-1:0] count_i;
    logic          busy_o;
    logic          done_o;
    logic          aborted_o;
    logic [AW-1:0] mem_adr_o;
    logic          mem_cyc_o;
    logic          mem_stb_o;
    logic [1:0]    mem_sel_o;
    logic [15:0]   mem_dat_i;
    logic          mem_ack_i;
    logic          mem_stall_i;
    logic [2:0]    sia_adr_o;
    logic          sia_cyc_o;
    logic          sia_stb_o;
    logic          sia_we_o;
    logic [1:0]    sia_sel_o;
    logic [15:0]   sia_dat_o;
    logic          sia_ack_i;
    logic          sia_stall_i;
    logic          dreq_i;

    always #5 clk = ~clk;

    sia_txdma dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .src_adr_i   (src_adr_i),
        .count_i     (count_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .aborted_o   (aborted_o),
        .mem_adr_o   (mem_adr_o),
        .mem_cyc_o   (mem_cyc_o),
        .mem_stb_o   (mem_stb_o),
        .mem_sel_o   (mem_sel_o),
        .mem_dat_i   (mem_dat_i),
        .mem_ack_i   (mem_ack_i),
        .mem_stall_i (mem_stall_i),
        .sia_adr_o   (sia_adr_o),
        .sia_cyc_o   (sia_cyc_o),
        .sia_stb_o   (sia_stb_o),
        .sia_we_o    (sia_we_o),
        .sia_sel_o   (sia_sel_o),
        .sia_dat_o   (sia_dat_o),
        .sia_ack_i   (sia_ack_i),
        .sia_stall_i (sia_stall_i),
        .dreq_i      (dreq_i)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc_cnt  = 0;
    int t0       = 0;
    int writes   = 0;
    int cyc_seen = 0;
    int overlap  = 0;
    int dreq_viol = 0;
    int first_wr_cyc = -1;
    logic dreq_watch = 1'b0;
    logic [AW-1:0] mem_base = '0;
    logic [AW-1:0] exp_mem[$];
    logic [15:0]   exp_sia[$];

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Zero-wait slaves: ack the cycle after an accepted strobe.
    // Memory data is 0xA001 for the word at mem_base, +1 per following word.
    always @(posedge clk) begin
        mem_ack_i <= mem_stb_o && !mem_stall_i;
        mem_dat_i <= 16'hA001 + 16'(mem_adr_o - mem_base);
        sia_ack_i <= sia_stb_o && !sia_stall_i;
    end

    // Monitor: compares presented strobes against the scoreboard queues.
    always @(negedge clk) begin
        if (mem_cyc_o || sia_cyc_o) cyc_seen++;
        if (mem_cyc_o && sia_cyc_o) overlap++;
        if (dreq_watch && !dreq_i && sia_cyc_o) dreq_viol++;
        if (mem_stb_o) begin
            if (exp_mem.size() == 0) begin
                check("mem_unexpected_stb", 64'(mem_adr_o), 64'hFFFF_FFFF);
            end else begin
                check("mem_adr", 64'(mem_adr_o), 64'(exp_mem[0]));
                check("mem_sel", 64'(mem_sel_o), 64'h3);
                if (!mem_stall_i) void'(exp_mem.pop_front());
            end
        end
        if (sia_stb_o) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc_cnt;
            if (exp_sia.size() == 0) begin
                check("sia_unexpected_stb", 64'(sia_dat_o), 64'hFFFF_FFFF);
            end else begin
                check("sia_dat", 64'(sia_dat_o), 64'(exp_sia[0]));
                check("sia_ctl", 64'({sia_adr_o, sia_we_o, sia_sel_o}), 64'({3'b010, 1'b1, 2'b11}));
                if (!sia_stall_i) begin
                    void'(exp_sia.pop_front());
                    writes++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [AW-1:0] adr, input logic [CW-1:0] cnt);
        src_adr_i = adr;
        count_i   = cnt;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        t0        = cyc_cnt;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                lat = cyc_cnt - t0;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy_o, done_o, aborted_o, mem_adr_o, mem_cyc_o, mem_stb_o,
                    mem_sel_o, sia_adr_o, sia_cyc_o, sia_stb_o, sia_we_o,
                    sia_sel_o, sia_dat_o});
    endfunction

    int lat;
    int rise;

    initial begin
        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        src_adr_i = '0; count_i = '0;
        mem_stall_i = 1'b0; sia_stall_i = 1'b0; dreq_i = 1'b1;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 64'h0);
        reset_i = 1'b0;
        tick();

        // Zero-length transfer.
        cyc_seen = 0;
        start('0, '0);
        check("zero_done", 64'(done_o), 64'h1);
        check("zero_busy", 64'(busy_o), 64'h0);
        tick();
        check("zero_done_width", 64'(done_o), 64'h0);
        repeat (3) tick();
        check("zero_no_cyc", 64'(cyc_seen), 64'h0);

        // Three words, zero-wait slaves, dreq high.
        mem_base = 23'h000100;
        exp_mem.push_back(23'h000100); exp_mem.push_back(23'h000101); exp_mem.push_back(23'h000102);
        exp_sia.push_back(16'hA001); exp_sia.push_back(16'hA002); exp_sia.push_back(16'hA003);
        writes = 0;
        start(23'h000100, 16'd3);
        wait_done(40, lat);
        check("basic_latency", 64'(lat), 64'd15);
        check("basic_busy_at_done", 64'(busy_o), 64'h0);
        tick();
        check("basic_done_width", 64'(done_o), 64'h0);
        check("basic_writes", 64'(writes), 64'd3);
        check("basic_queues", 64'(exp_mem.size() + exp_sia.size()), 64'd0);

        // dreq held low for 20 cycles after the first read.
        exp_mem.push_back(23'h000100); exp_mem.push_back(23'h000101); exp_mem.push_back(23'h000102);
        exp_sia.push_back(16'hA001); exp_sia.push_back(16'hA002); exp_sia.push_back(16'hA003);
        dreq_i = 1'b0; dreq_watch = 1'b1; first_wr_cyc = -1; dreq_viol = 0;
        start(23'h000100, 16'd3);
        repeat (2) tick();
        repeat (20) tick();
        rise = cyc_cnt;
        dreq_i = 1'b1;
        wait_done(80, lat);
        dreq_watch = 1'b0;
        check("dreq_latency", 64'(lat), 64'd35);
        check("dreq_first_write", 64'(first_wr_cyc), 64'(rise + 1));
        check("dreq_no_early_cyc", 64'(dreq_viol), 64'd0);
        tick();

        // Memory stall 4 cycles, SIA stall 2 cycles on the first word.
        exp_mem.push_back(23'h000100); exp_mem.push_back(23'h000101); exp_mem.push_back(23'h000102);
        exp_sia.push_back(16'hA001); exp_sia.push_back(16'hA002); exp_sia.push_back(16'hA003);
        mem_stall_i = 1'b1; sia_stall_i = 1'b1;
        start(23'h000100, 16'd3);
        repeat (4) tick();
        mem_stall_i = 1'b0;
        for (int i = 0; i < 20 && !sia_stb_o; i++) tick();
        repeat (2) tick();
        sia_stall_i = 1'b0;
        wait_done(60, lat);
        check("stall_latency", 64'(lat), 64'd21);
        tick();
        check("stall_queues", 64'(exp_mem.size() + exp_sia.size()), 64'd0);

        // Abort during the second WAIT_DREQ of a five-word transfer.
        mem_base = 23'h000200;
        exp_mem.push_back(23'h000200); exp_mem.push_back(23'h000201);
        exp_sia.push_back(16'hA001);
        writes = 0;
        start(23'h000200, 16'd5);
        repeat (3) tick();
        dreq_i = 1'b0;
        repeat (4) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_cyc", 64'({mem_cyc_o, mem_stb_o, sia_cyc_o, sia_stb_o}), 64'h0);
        check("abort_status", 64'({busy_o, done_o, aborted_o}), 64'({1'b0, 1'b1, 1'b1}));
        tick();
        check("abort_done_width", 64'({done_o, aborted_o}), 64'({1'b0, 1'b1}));
        check("abort_writes", 64'(writes), 64'd1);
        check("abort_queues", 64'(exp_mem.size() + exp_sia.size()), 64'd0);
        dreq_i = 1'b1;
        mem_base = 23'h000300;
        exp_mem.push_back(23'h000300);
        exp_sia.push_back(16'hA001);
        start(23'h000300, 16'd1);
        check("restart_clears_aborted", 64'({busy_o, aborted_o}), 64'({1'b1, 1'b0}));
        wait_done(20, lat);
        check("restart_latency", 64'(lat), 64'd5);
        tick();

        // Address wrap, then reset in the second WR_WAIT.
        mem_base = 23'h7FFFFF;
        exp_mem.push_back(23'h7FFFFF); exp_mem.push_back(23'h000000);
        exp_sia.push_back(16'hA001); exp_sia.push_back(16'hA002);
        writes = 0;
        start(23'h7FFFFF, 16'd2);
        repeat (9) tick();
        check("wrap_in_wr_wait", 64'({sia_cyc_o, sia_stb_o, busy_o}), 64'({1'b1, 1'b0, 1'b1}));
        reset_i = 1'b1;
        tick();
        check("midreset_outputs", all_outs(), 64'h0);
        tick();
        check("midreset_no_done", 64'(done_o), 64'h0);
        reset_i = 1'b0;
        tick();
        check("wrap_writes", 64'(writes), 64'd2);
        check("wrap_queues", 64'(exp_mem.size() + exp_sia.size()), 64'd0);
        check("no_port_overlap", 64'(overlap), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
